// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, writeback port numbering and the per-entry record for the reorder buffer.
// Flat buses throughout carry element 0 in their most significant field.
package reorder_buffer_pkg;

   localparam int ROB_ENTRIES  = 16;
   localparam int IDX_W        = 4;
   localparam int DATA_W       = 16;
   localparam int RT_W         = 4;
   localparam int CNT_W        = 5;
   localparam int ALLOC_W      = 4;
   localparam int SLOT_W       = 2;
   localparam int NUM_WB_PORTS = 4;
   localparam int COMMIT_W     = 2;

   localparam int FXU0 = 0;
   localparam int FXU1 = 1;
   localparam int LSU  = 2;
   localparam int BR   = 3;

   typedef struct packed {
      logic              busy;
      logic              done;
      logic              writes_reg;
      logic [RT_W-1:0]   rt;
      logic [DATA_W-1:0] value;
   } rob_entry_t;

   function automatic logic [2:0] popcount4(input logic [3:0] bits);
      return {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};
   endfunction

endpackage

// File: rtl/reorder_buffer_checker.sv
// Protocol checks on the reorder buffer inputs: contiguous allocation and unique writeback targets.
module reorder_buffer_checker
   import reorder_buffer_pkg::*;
(
   input logic                          clk,
   input logic                          rst_n,
   input logic [ALLOC_W-1:0]            alloc_valid_flat,
   input logic [NUM_WB_PORTS-1:0]       wb_valid_flat,
   input logic [NUM_WB_PORTS*IDX_W-1:0] wb_rob_idx_flat
);

   logic [NUM_WB_PORTS*NUM_WB_PORTS-1:0] pair_hit_s;

   for (genvar a = 0; a < NUM_WB_PORTS; a++) begin : g_a
      for (genvar b = 0; b < NUM_WB_PORTS; b++) begin : g_b
         if (b > a) begin : g_pair
            assign pair_hit_s[a*NUM_WB_PORTS+b] = wb_valid_flat[a] & wb_valid_flat[b] &
               (wb_rob_idx_flat[a*IDX_W +: IDX_W] == wb_rob_idx_flat[b*IDX_W +: IDX_W]);
         end else begin : g_none
            assign pair_hit_s[a*NUM_WB_PORTS+b] = 1'b0;
         end
      end
   end

   a_wb_unique_target: assert property (@(posedge clk) disable iff (!rst_n) pair_hit_s == '0);

   a_alloc_prefix: assert property (@(posedge clk) disable iff (!rst_n)
      alloc_valid_flat inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111});

endmodule

// File: rtl/rob_entry.sv
// One reorder-buffer slot: allocation, result capture and release.
module rob_entry
   import reorder_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              clear,
   input  logic              alloc,
   input  logic [RT_W-1:0]   alloc_rt,
   input  logic              alloc_writes_reg,
   input  logic              wb,
   input  logic [DATA_W-1:0] wb_value,
   output rob_entry_t        state
);

   rob_entry_t state_r;

   // Flush and retirement dominate; a result only lands on a live entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= '0;
      end else if (flush || clear) begin
         state_r.busy <= 1'b0;
         state_r.done <= 1'b0;
      end else if (alloc) begin
         state_r.busy       <= 1'b1;
         state_r.done       <= 1'b0;
         state_r.writes_reg <= alloc_writes_reg;
         state_r.rt         <= alloc_rt;
      end else if (wb && state_r.busy) begin
         state_r.done  <= 1'b1;
         state_r.value <= wb_value;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order retirement queue: 4-wide allocate, 4-port writeback, 2-wide commit.
// Full and empty are told apart by count, never by head == tail.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ALLOC_W-1:0]                alloc_valid_flat,
   input  logic [ALLOC_W*RT_W-1:0]           alloc_rt_flat,
   input  logic [ALLOC_W-1:0]                alloc_writes_reg_flat,
   output logic                              alloc_ready,
   output logic [IDX_W-1:0]                  alloc_base_idx,
   output logic [CNT_W-1:0]                  free_count,
   input  logic [NUM_WB_PORTS-1:0]           wb_valid_flat,
   input  logic [NUM_WB_PORTS*IDX_W-1:0]     wb_rob_idx_flat,
   input  logic [NUM_WB_PORTS*DATA_W-1:0]    wb_value_flat,
   input  logic                              flush,
   output logic [ROB_ENTRIES-1:0]            rob_output_valid_flat,
   output logic [ROB_ENTRIES*DATA_W-1:0]     rob_output_values_flat,
   output logic [COMMIT_W-1:0]               commit_valid_flat,
   output logic [COMMIT_W-1:0]               commit_we_flat,
   output logic [COMMIT_W*RT_W-1:0]          commit_rt_flat,
   output logic [COMMIT_W*DATA_W-1:0]        commit_value_flat,
   output logic [COMMIT_W*IDX_W-1:0]         commit_rob_idx_flat
);

   logic [IDX_W-1:0]        head_r;
   logic [IDX_W-1:0]        tail_r;
   logic [CNT_W-1:0]        count_r;
   logic [IDX_W-1:0]        head1_s;
   logic [2:0]              k_alloc_s;
   logic                    accept_s;
   logic [CNT_W-1:0]        alloc_n_s;
   logic [CNT_W-1:0]        commit_n_s;
   logic                    c0_s;
   logic                    c1_s;
   rob_entry_t              head_e_s;
   rob_entry_t              next_e_s;
   rob_entry_t              entry_s [ROB_ENTRIES];

   logic [RT_W-1:0]         slot_rt_s  [ALLOC_W];
   logic [ALLOC_W-1:0]      slot_wr_s;
   logic [NUM_WB_PORTS-1:0] wb_v_s;
   logic [IDX_W-1:0]        wb_idx_s   [NUM_WB_PORTS];
   logic [DATA_W-1:0]       wb_val_s   [NUM_WB_PORTS];

   for (genvar k = 0; k < ALLOC_W; k++) begin : g_slot
      assign slot_rt_s[k] = alloc_rt_flat[(ALLOC_W-1-k)*RT_W +: RT_W];
      assign slot_wr_s[k] = alloc_writes_reg_flat[ALLOC_W-1-k];
   end

   for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_port
      assign wb_v_s[p]   = wb_valid_flat[NUM_WB_PORTS-1-p];
      assign wb_idx_s[p] = wb_rob_idx_flat[(NUM_WB_PORTS-1-p)*IDX_W +: IDX_W];
      assign wb_val_s[p] = wb_value_flat[(NUM_WB_PORTS-1-p)*DATA_W +: DATA_W];
   end

   // free_count comes from registered count only, so same-cycle commits never free space early.
   assign free_count     = CNT_W'(ROB_ENTRIES) - count_r;
   assign k_alloc_s      = popcount4(alloc_valid_flat);
   assign alloc_ready    = ({2'b00, k_alloc_s} <= free_count);
   assign accept_s       = !flush && alloc_ready && (k_alloc_s != 3'd0);
   assign alloc_n_s      = accept_s ? {2'b00, k_alloc_s} : {CNT_W{1'b0}};
   assign alloc_base_idx = tail_r;

   assign head1_s    = head_r + 4'd1;
   assign head_e_s   = entry_s[head_r];
   assign next_e_s   = entry_s[head1_s];
   assign c0_s       = !flush && head_e_s.busy && head_e_s.done;
   assign c1_s       = c0_s && next_e_s.busy && next_e_s.done;
   assign commit_n_s = {4'b0000, c0_s} + {4'b0000, c1_s};

   for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_entry
      logic [IDX_W-1:0]        offset_s;
      logic                    alloc_en_s;
      logic                    clear_s;
      logic [NUM_WB_PORTS-1:0] wb_hit_s;
      logic [DATA_W-1:0]       wb_sel_s;

      // Slot k of the request lands on entry tail+k; valid slots form a prefix.
      assign offset_s   = IDX_W'(i) - tail_r;
      assign alloc_en_s = accept_s && (offset_s < {1'b0, k_alloc_s});
      assign clear_s    = (c0_s && (head_r == IDX_W'(i))) || (c1_s && (head1_s == IDX_W'(i)));

      for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_hit
         assign wb_hit_s[p] = wb_v_s[p] && (wb_idx_s[p] == IDX_W'(i));
      end

      // Lower port number wins if two ports ever target this entry together.
      always_comb begin
         wb_sel_s = wb_val_s[BR];
         if (wb_hit_s[FXU0]) begin
            wb_sel_s = wb_val_s[FXU0];
         end else if (wb_hit_s[FXU1]) begin
            wb_sel_s = wb_val_s[FXU1];
         end else if (wb_hit_s[LSU]) begin
            wb_sel_s = wb_val_s[LSU];
         end else begin
            wb_sel_s = wb_val_s[BR];
         end
      end

      rob_entry u_entry (
         .clk              (clk),
         .rst_n            (rst_n),
         .flush            (flush),
         .clear            (clear_s),
         .alloc            (alloc_en_s),
         .alloc_rt         (slot_rt_s[offset_s[SLOT_W-1:0]]),
         .alloc_writes_reg (slot_wr_s[offset_s[SLOT_W-1:0]]),
         .wb               (|wb_hit_s),
         .wb_value         (wb_sel_s),
         .state            (entry_s[i])
      );

      assign rob_output_valid_flat[ROB_ENTRIES-1-i] = entry_s[i].busy & entry_s[i].done;
      assign rob_output_values_flat[(ROB_ENTRIES-1-i)*DATA_W +: DATA_W] = entry_s[i].value;
   end

   // Queue pointers; flush collapses the tail onto the head.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_r  <= {IDX_W{1'b0}};
         tail_r  <= {IDX_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         tail_r  <= head_r;
         count_r <= {CNT_W{1'b0}};
      end else begin
         head_r  <= head_r + commit_n_s[IDX_W-1:0];
         tail_r  <= tail_r + alloc_n_s[IDX_W-1:0];
         count_r <= count_r + alloc_n_s - commit_n_s;
      end
   end

   // Retirement record presented for one cycle after the entries leave the queue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         commit_valid_flat   <= {COMMIT_W{1'b0}};
         commit_we_flat      <= {COMMIT_W{1'b0}};
         commit_rt_flat      <= {(COMMIT_W*RT_W){1'b0}};
         commit_value_flat   <= {(COMMIT_W*DATA_W){1'b0}};
         commit_rob_idx_flat <= {(COMMIT_W*IDX_W){1'b0}};
      end else begin
         commit_valid_flat   <= {c0_s, c1_s};
         commit_we_flat      <= {c0_s & head_e_s.writes_reg, c1_s & next_e_s.writes_reg};
         commit_rt_flat      <= {c0_s ? head_e_s.rt : {RT_W{1'b0}},
                                 c1_s ? next_e_s.rt : {RT_W{1'b0}}};
         commit_value_flat   <= {c0_s ? head_e_s.value : {DATA_W{1'b0}},
                                 c1_s ? next_e_s.value : {DATA_W{1'b0}}};
         commit_rob_idx_flat <= {c0_s ? head_r : {IDX_W{1'b0}},
                                 c1_s ? head1_s : {IDX_W{1'b0}}};
      end
   end

   reorder_buffer_checker u_checker (
      .clk              (clk),
      .rst_n            (rst_n),
      .alloc_valid_flat (alloc_valid_flat),
      .wb_valid_flat    (wb_valid_flat),
      .wb_rob_idx_flat  (wb_rob_idx_flat)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, writeback, in-order commit, full, wrap, flush, reset.
module tb_reorder_buffer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   alloc_valid_flat;
   logic [15:0]  alloc_rt_flat;
   logic [3:0]   alloc_writes_reg_flat;
   logic         alloc_ready;
   logic [3:0]   alloc_base_idx;
   logic [4:0]   free_count;
   logic [3:0]   wb_valid_flat;
   logic [15:0]  wb_rob_idx_flat;
   logic [63:0]  wb_value_flat;
   logic         flush;
   logic [15:0]  rob_output_valid_flat;
   logic [255:0] rob_output_values_flat;
   logic [1:0]   commit_valid_flat;
   logic [1:0]   commit_we_flat;
   logic [7:0]   commit_rt_flat;
   logic [31:0]  commit_value_flat;
   logic [7:0]   commit_rob_idx_flat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .alloc_valid_flat       (alloc_valid_flat),
      .alloc_rt_flat          (alloc_rt_flat),
      .alloc_writes_reg_flat  (alloc_writes_reg_flat),
      .alloc_ready            (alloc_ready),
      .alloc_base_idx         (alloc_base_idx),
      .free_count             (free_count),
      .wb_valid_flat          (wb_valid_flat),
      .wb_rob_idx_flat        (wb_rob_idx_flat),
      .wb_value_flat          (wb_value_flat),
      .flush                  (flush),
      .rob_output_valid_flat  (rob_output_valid_flat),
      .rob_output_values_flat (rob_output_values_flat),
      .commit_valid_flat      (commit_valid_flat),
      .commit_we_flat         (commit_we_flat),
      .commit_rt_flat         (commit_rt_flat),
      .commit_value_flat      (commit_value_flat),
      .commit_rob_idx_flat    (commit_rob_idx_flat)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      alloc_valid_flat = 4'b0000; alloc_rt_flat = 16'h0000; alloc_writes_reg_flat = 4'b0000;
      wb_valid_flat = 4'b0000; wb_rob_idx_flat = 16'h0000; wb_value_flat = 64'h0;
      flush = 1'b0;
      #1;
   endtask

   task automatic do_alloc(input logic [3:0] v, input logic [15:0] rt, input logic [3:0] wr);
      alloc_valid_flat = v; alloc_rt_flat = rt; alloc_writes_reg_flat = wr;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle_inputs();
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL reset_free_count: got %0d expected 16", free_count); end
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
      checks++; if (alloc_base_idx !== 4'd0) begin errors++; $display("FAIL reset_base: got %0d expected 0", alloc_base_idx); end
      checks++; if (rob_output_valid_flat !== 16'h0000) begin errors++; $display("FAIL reset_rob_valid: got %h expected 0000", rob_output_valid_flat); end
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL reset_commit_valid: got %b expected 00", commit_valid_flat); end
      checks++; if (rob_output_values_flat !== 256'h0) begin errors++; $display("FAIL reset_rob_values: got %h expected 0", rob_output_values_flat); end
   endtask

   task automatic test_alloc;
      alloc_valid_flat = 4'b1111; alloc_rt_flat = 16'h1234; alloc_writes_reg_flat = 4'b1111;
      #1;
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL alloc4_ready: got %b expected 1", alloc_ready); end
      checks++; if (alloc_base_idx !== 4'd0) begin errors++; $display("FAIL alloc4_base_before: got %0d expected 0", alloc_base_idx); end
      tick();
      idle_inputs();
      checks++; if (alloc_base_idx !== 4'd4) begin errors++; $display("FAIL alloc4_base_after: got %0d expected 4", alloc_base_idx); end
      checks++; if (free_count !== 5'd12) begin errors++; $display("FAIL alloc4_free: got %0d expected 12", free_count); end
      checks++; if (rob_output_valid_flat !== 16'h0000) begin errors++; $display("FAIL alloc4_rob_valid: got %h expected 0000", rob_output_valid_flat); end
   endtask

   task automatic test_writeback_commit;
      wb_valid_flat = 4'b1100; wb_rob_idx_flat = 16'h0100; wb_value_flat = 64'h00AA_00BB_0000_0000;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'hC000) begin errors++; $display("FAIL wb_rob_valid: got %h expected c000", rob_output_valid_flat); end
      checks++; if (rob_output_values_flat[255:224] !== 32'h00AA_00BB) begin errors++; $display("FAIL wb_rob_values: got %h expected 00aa00bb", rob_output_values_flat[255:224]); end
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL wb_commit_early: got %b expected 00", commit_valid_flat); end
      tick();
      checks++; if (commit_valid_flat !== 2'b11) begin errors++; $display("FAIL c01_valid: got %b expected 11", commit_valid_flat); end
      checks++; if (commit_we_flat !== 2'b11) begin errors++; $display("FAIL c01_we: got %b expected 11", commit_we_flat); end
      checks++; if (commit_rt_flat !== 8'h12) begin errors++; $display("FAIL c01_rt: got %h expected 12", commit_rt_flat); end
      checks++; if (commit_value_flat !== 32'h00AA_00BB) begin errors++; $display("FAIL c01_value: got %h expected 00aa00bb", commit_value_flat); end
      checks++; if (commit_rob_idx_flat !== 8'h01) begin errors++; $display("FAIL c01_idx: got %h expected 01", commit_rob_idx_flat); end
      checks++; if (free_count !== 5'd14) begin errors++; $display("FAIL c01_free: got %0d expected 14", free_count); end
      tick();
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL c01_one_cycle: got %b expected 00", commit_valid_flat); end
   endtask

   task automatic test_out_of_order;
      wb_valid_flat = 4'b0010; wb_rob_idx_flat = 16'h0030; wb_value_flat = 64'h0000_0000_0333_0000;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'h1000) begin errors++; $display("FAIL ooo_rob_valid3: got %h expected 1000", rob_output_valid_flat); end
      tick();
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL ooo_hold: got %b expected 00", commit_valid_flat); end
      wb_valid_flat = 4'b0001; wb_rob_idx_flat = 16'h0002; wb_value_flat = 64'h0000_0000_0000_0222;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'h3000) begin errors++; $display("FAIL ooo_rob_valid23: got %h expected 3000", rob_output_valid_flat); end
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL ooo_hold2: got %b expected 00", commit_valid_flat); end
      tick();
      checks++; if (commit_valid_flat !== 2'b11) begin errors++; $display("FAIL ooo_valid: got %b expected 11", commit_valid_flat); end
      checks++; if (commit_rt_flat !== 8'h34) begin errors++; $display("FAIL ooo_rt: got %h expected 34", commit_rt_flat); end
      checks++; if (commit_value_flat !== 32'h0222_0333) begin errors++; $display("FAIL ooo_value: got %h expected 02220333", commit_value_flat); end
      checks++; if (commit_rob_idx_flat !== 8'h23) begin errors++; $display("FAIL ooo_idx: got %h expected 23", commit_rob_idx_flat); end
      checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL ooo_free: got %0d expected 16", free_count); end
   endtask

   task automatic test_full;
      do_alloc(4'b1111, 16'hAAAA, 4'b0000);
      do_alloc(4'b1111, 16'hAAAA, 4'b0000);
      do_alloc(4'b1111, 16'hAAAA, 4'b0000);
      do_alloc(4'b1100, 16'hAA00, 4'b0000);
      checks++; if (free_count !== 5'd2) begin errors++; $display("FAIL full14_free: got %0d expected 2", free_count); end
      checks++; if (alloc_base_idx !== 4'd2) begin errors++; $display("FAIL full14_base: got %0d expected 2", alloc_base_idx); end
      alloc_valid_flat = 4'b1111; alloc_rt_flat = 16'hCCCC;
      #1;
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_req4_ready: got %b expected 0", alloc_ready); end
      tick();
      idle_inputs();
      checks++; if (alloc_base_idx !== 4'd2) begin errors++; $display("FAIL full_req4_tail: got %0d expected 2", alloc_base_idx); end
      checks++; if (free_count !== 5'd2) begin errors++; $display("FAIL full_req4_free: got %0d expected 2", free_count); end
      alloc_valid_flat = 4'b1100; alloc_rt_flat = 16'hBB00;
      #1;
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_req2_ready: got %b expected 1", alloc_ready); end
      tick();
      idle_inputs();
      checks++; if (free_count !== 5'd0) begin errors++; $display("FAIL full_free0: got %0d expected 0", free_count); end
      checks++; if (alloc_base_idx !== 4'd4) begin errors++; $display("FAIL full_tail: got %0d expected 4", alloc_base_idx); end
      alloc_valid_flat = 4'b1000;
      #1;
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_req1_ready: got %b expected 0", alloc_ready); end
      idle_inputs();
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_req0_ready: got %b expected 1", alloc_ready); end
   endtask

   task automatic test_drain_flush;
      wb_valid_flat = 4'b1111; wb_rob_idx_flat = 16'h4567; wb_value_flat = 64'h0004_0005_0006_0007;
      tick();
      wb_rob_idx_flat = 16'h89AB; wb_value_flat = 64'h0008_0009_000A_000B;
      tick();
      idle_inputs();
      checks++; if (commit_rob_idx_flat !== 8'h45) begin errors++; $display("FAIL drain_idx45: got %h expected 45", commit_rob_idx_flat); end
      checks++; if (commit_we_flat !== 2'b00) begin errors++; $display("FAIL drain_we: got %b expected 00", commit_we_flat); end
      checks++; if (commit_value_flat !== 32'h0004_0005) begin errors++; $display("FAIL drain_value: got %h expected 00040005", commit_value_flat); end
      checks++; if (commit_rt_flat !== 8'hAA) begin errors++; $display("FAIL drain_rt: got %h expected aa", commit_rt_flat); end
      tick(); tick(); tick();
      checks++; if (commit_rob_idx_flat !== 8'hAB) begin errors++; $display("FAIL drain_idxab: got %h expected ab", commit_rob_idx_flat); end
      checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL drain_free: got %0d expected 8", free_count); end
      flush = 1'b1;
      tick();
      idle_inputs();
      checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL drainflush_free: got %0d expected 16", free_count); end
      checks++; if (alloc_base_idx !== 4'd12) begin errors++; $display("FAIL drainflush_tail: got %0d expected 12", alloc_base_idx); end
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL drainflush_commit: got %b expected 00", commit_valid_flat); end
   endtask

   task automatic test_wrap;
      alloc_valid_flat = 4'b1111; alloc_rt_flat = 16'h5678; alloc_writes_reg_flat = 4'b1111;
      #1;
      checks++; if (alloc_base_idx !== 4'd12) begin errors++; $display("FAIL wrap_base12: got %0d expected 12", alloc_base_idx); end
      tick();
      checks++; if (alloc_base_idx !== 4'd0) begin errors++; $display("FAIL wrap_base0: got %0d expected 0", alloc_base_idx); end
      alloc_rt_flat = 16'h9ABC;
      tick();
      idle_inputs();
      checks++; if (alloc_base_idx !== 4'd4) begin errors++; $display("FAIL wrap_base4: got %0d expected 4", alloc_base_idx); end
      checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL wrap_free8: got %0d expected 8", free_count); end
      wb_valid_flat = 4'b1111; wb_rob_idx_flat = 16'hCDEF; wb_value_flat = 64'h100C_100D_100E_100F;
      tick();
      checks++; if (rob_output_valid_flat !== 16'h000F) begin errors++; $display("FAIL wrap_rob_valid: got %h expected 000f", rob_output_valid_flat); end
      wb_rob_idx_flat = 16'h0123; wb_value_flat = 64'h1000_1001_1002_1003;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'hF003) begin errors++; $display("FAIL wrap_rob_valid2: got %h expected f003", rob_output_valid_flat); end
      checks++; if (commit_rob_idx_flat !== 8'hCD || commit_rt_flat !== 8'h56 || commit_value_flat !== 32'h100C_100D) begin errors++; $display("FAIL wrap_c1: got idx %h rt %h val %h expected cd 56 100c100d", commit_rob_idx_flat, commit_rt_flat, commit_value_flat); end
      tick();
      checks++; if (commit_rob_idx_flat !== 8'hEF || commit_rt_flat !== 8'h78 || commit_value_flat !== 32'h100E_100F) begin errors++; $display("FAIL wrap_c2: got idx %h rt %h val %h expected ef 78 100e100f", commit_rob_idx_flat, commit_rt_flat, commit_value_flat); end
      tick();
      checks++; if (commit_rob_idx_flat !== 8'h01 || commit_rt_flat !== 8'h9A || commit_value_flat !== 32'h1000_1001) begin errors++; $display("FAIL wrap_c3: got idx %h rt %h val %h expected 01 9a 10001001", commit_rob_idx_flat, commit_rt_flat, commit_value_flat); end
      tick();
      checks++; if (commit_rob_idx_flat !== 8'h23 || commit_rt_flat !== 8'hBC || commit_we_flat !== 2'b11) begin errors++; $display("FAIL wrap_c4: got idx %h rt %h we %b expected 23 bc 11", commit_rob_idx_flat, commit_rt_flat, commit_we_flat); end
      tick();
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL wrap_done_commit: got %b expected 00", commit_valid_flat); end
      checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL wrap_done_free: got %0d expected 16", free_count); end
   endtask

   task automatic test_flush;
      do_alloc(4'b1111, 16'h1111, 4'b1111);
      do_alloc(4'b1100, 16'h2200, 4'b1111);
      checks++; if (alloc_base_idx !== 4'd10 || free_count !== 5'd10) begin errors++; $display("FAIL flush_setup: got base %0d free %0d expected 10 10", alloc_base_idx, free_count); end
      wb_valid_flat = 4'b1000; wb_rob_idx_flat = 16'h5000; wb_value_flat = 64'h5555_0000_0000_0000;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'h0400) begin errors++; $display("FAIL flush_pre_valid: got %h expected 0400", rob_output_valid_flat); end
      checks++; if (rob_output_values_flat[175:160] !== 16'h5555) begin errors++; $display("FAIL flush_pre_value5: got %h expected 5555", rob_output_values_flat[175:160]); end
      flush = 1'b1;
      wb_valid_flat = 4'b1000; wb_rob_idx_flat = 16'h4000; wb_value_flat = 64'h4444_0000_0000_0000;
      alloc_valid_flat = 4'b1000; alloc_rt_flat = 16'h7000;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'h0000) begin errors++; $display("FAIL flush_rob_valid: got %h expected 0000", rob_output_valid_flat); end
      checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL flush_free: got %0d expected 16", free_count); end
      checks++; if (alloc_base_idx !== 4'd4) begin errors++; $display("FAIL flush_tail: got %0d expected 4", alloc_base_idx); end
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL flush_commit: got %b expected 00", commit_valid_flat); end
      checks++; if (rob_output_values_flat[191:176] !== 16'h0004) begin errors++; $display("FAIL flush_wb_dropped: got %h expected 0004", rob_output_values_flat[191:176]); end
   endtask

   task automatic test_reset_mid;
      do_alloc(4'b1111, 16'h3333, 4'b1111);
      wb_valid_flat = 4'b1100; wb_rob_idx_flat = 16'h4500; wb_value_flat = 64'h0044_0055_0000_0000;
      tick();
      idle_inputs();
      checks++; if (rob_output_valid_flat !== 16'h0C00) begin errors++; $display("FAIL rstmid_pre_valid: got %h expected 0c00", rob_output_valid_flat); end
      rst_n = 1'b0;
      tick();
      checks++; if (commit_valid_flat !== 2'b00 || commit_rob_idx_flat !== 8'h00 || commit_value_flat !== 32'h0) begin errors++; $display("FAIL rstmid_commit: got v %b idx %h val %h expected 00 00 0", commit_valid_flat, commit_rob_idx_flat, commit_value_flat); end
      checks++; if (alloc_base_idx !== 4'd0 || free_count !== 5'd16 || alloc_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ptrs: got base %0d free %0d ready %b expected 0 16 1", alloc_base_idx, free_count, alloc_ready); end
      checks++; if (rob_output_valid_flat !== 16'h0000 || rob_output_values_flat !== 256'h0) begin errors++; $display("FAIL rstmid_rob: got valid %h expected 0000 and zero values", rob_output_valid_flat); end
      rst_n = 1'b1;
      tick();
      checks++; if (commit_valid_flat !== 2'b00) begin errors++; $display("FAIL rstmid_after: got %b expected 00", commit_valid_flat); end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_writeback_commit();
      test_out_of_order();
      test_full();
      test_drain_flush();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry in-order retirement queue that sits directly downstream of the instruction buffer.
- Allocates up to 4 entries per cycle for dispatched instructions and supplies the allocation base index.
- Captures results from the four functional units and exposes per-entry ready/value vectors for operand forwarding.
- Retires up to 2 completed entries per cycle, in order, to the register file.

Parameters:
- NUM_ENTRIES, 16, ROB depth (power of 2; index width IDX_W = log2 = 4)
- DATA_W, 16, result value width
- COMMIT_W, 2, maximum retirements per cycle

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid_flat  in  4  per-slot allocate request; slot 0 at MSB; must be a contiguous prefix from slot 0
- alloc_rt_flat  in  16  destination register per slot; slot 0 at bits [15:12]
- alloc_writes_reg_flat  in  4  slot writes a register
- alloc_ready  out  1  free entries >= requested count
- alloc_base_idx  out  4  tail pointer; slot k is assigned alloc_base_idx+k (mod 16)
- free_count  out  5  number of empty entries
- wb_valid_flat  in  4  writeback strobes, order {fxu_0, fxu_1, lsu, branch}, fxu_0 at MSB
- wb_rob_idx_flat  in  16  writeback target entry per port
- wb_value_flat  in  64  writeback value per port
- flush  in  1  discard all uncommitted entries
- rob_output_valid_flat  out  16  entry allocated and done; entry 0 at MSB
- rob_output_values_flat  out  256  entry values; entry 0 at bits [255:240]
- commit_valid_flat  out  2  retirement strobes, oldest at MSB
- commit_we_flat  out  2  retirement writes the register file
- commit_rt_flat  out  8  destination register
- commit_value_flat  out  32  value
- commit_rob_idx_flat  out  8  retiring entry index; the register file clears busy only if its owner matches

Behaviour:
- Per-entry state: busy, done, writes_reg, rt[3:0], value[15:0].
- Pointers: head[3:0], tail[3:0], count[4:0]. Pointer arithmetic is mod 16.
- free_count = 16 - count. It is computed from registered state only, so commits in the current cycle do not free space early.
- alloc_ready = (popcount(alloc_valid_flat) <= free_count). It is combinational.
- Allocation is all-or-nothing:
  - If any alloc_valid bit is set and alloc_ready = 0, nothing is allocated.
  - On accept at edge N: entries tail..tail+k-1 get busy=1, done=0, and rt/writes_reg loaded; tail advances by k.
- Writeback at edge N sets done=1 and value=wb_value for the target entry. rob_output_valid for that entry is high from cycle N+1.
  - Writeback to an entry with busy=0 is ignored.
  - Two ports targeting the same index in one cycle is illegal; the assertion fires, and the lower port number (fxu_0) wins.
- Commit decision is made each cycle from registered state:
  - c0 = busy[head] & done[head]
  - c1 = c0 & busy[head+1] & done[head+1]
- At the edge: retired entries are cleared (busy=0, done=0); head advances by c0+c1; count = count + k_alloc - (c0+c1).
- commit_* outputs are registered: entries retired at edge N appear on commit_* during cycle N+1 for exactly one cycle. commit_we = writes_reg of the retired entry.
- Simultaneous events:
  - Allocation and commit in the same cycle are both applied.
  - A retiring entry slot may be reallocated only in a later cycle, because free_count excludes it.
- Flush has priority over everything:
  - All busy/done bits clear; tail <= head; count <= 0.
  - No commit and no allocation that cycle; commit_valid is 0 the next cycle.
  - Writebacks in the flush cycle are dropped.
- Wrap-around: 16 allocations from head=12 give tail=12 with count=16. Full and empty are distinguished by count, never by pointer equality.
- Reset (rst_n=0 at an edge):
  - Pointers and count = 0; all entry busy/done/value = 0.
  - All commit_* outputs = 0; rob_output_* = 0; alloc_base_idx = 0; free_count = 16; alloc_ready = 1.
- Reset mid-operation discards all entries with no commits.

Decomposition:
- Shared package holds:
  - ROB_ENTRIES=16, IDX_W=4, DATA_W=16, NUM_WB_PORTS=4, COMMIT_W=2
  - WB port index constants: FXU0=0, FXU1=1, LSU=2, BR=3
  - Flatten/unflatten ordering convention: element 0 at MSB
- One sub-module: rob_entry (single-entry state register with alloc/writeback/clear/flush inputs), instantiated 16 times. Pointer, count and commit logic stay in the top.

Test Plan:
- Reset, then allocate 4 slots with rt={1,2,3,4} and writes_reg=1111 → alloc_base_idx 0→4, free_count 12, rob_output_valid_flat=0.
- Writeback fxu_0 idx0=0x00AA and fxu_1 idx1=0x00BB in the same cycle → next cycle entries 0 and 1 are valid. The cycle after, commit_valid=11, commit_rt={1,2}, commit_value={00AA,00BB}, commit_rob_idx={0,1}. Head=2.
- Writeback idx1 before idx0 → no commit until idx0 is done; then both retire together. In-order retirement is held.
- Fill to 14 entries, then request 4 → alloc_ready=0, tail unchanged. Request 2 → accepted, free_count=0.
- Head=12 wrap: allocate 8 → indices 12..15,0..3; tail=4. Writebacks complete all 8, and retirement spans 15→0 in four cycles.
- With 6 entries in flight, assert flush together with wb_valid for idx0 → next cycle rob_output_valid_flat=0, count 0, tail=head, commit_valid=0. Assert rst_n=0 mid-stream → all outputs at their reset values.
